// File: rtl/gpu_sched_pkg.sv
// Shared types and helpers for the GPU job scheduler.
// Job record layout and the round-robin unit picker live here.
package gpu_sched_pkg;

    localparam int N_UNITS    = 8;
    localparam int UNIT_IDX_W = $clog2(N_UNITS);
    localparam int JOB_ADDR_W = 32;
    localparam int JOB_CFG_W  = 16;
    localparam int JOB_TAG_W  = 4;

    typedef struct packed {
        logic [JOB_ADDR_W-1:0] a_addr;
        logic [JOB_ADDR_W-1:0] b_addr;
        logic [JOB_ADDR_W-1:0] c_addr;
        logic [JOB_CFG_W-1:0]  cfg;
        logic [JOB_TAG_W-1:0]  tag;
    } gpu_job_t;

    // First set bit of elig at or after ptr, wrapping; caller checks |elig.
    function automatic logic [UNIT_IDX_W-1:0] rr_pick(input logic [N_UNITS-1:0] elig,
                                                      input logic [UNIT_IDX_W-1:0] ptr);
        logic [UNIT_IDX_W-1:0] pick;
        logic                  found;
        int                    idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_UNITS; i++) begin
            idx = (int'(ptr) + i) % N_UNITS;
            if (!found && elig[idx[UNIT_IDX_W-1:0]]) begin
                pick  = idx[UNIT_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/gpu_job_fifo.sv
// Job queue: DEPTH entries of gpu_job_t, wrap-bit pointers for full/empty.
// Latency: a pushed job is at the head the cycle after the push.
// Backpressure: caller must not push when full nor pop when empty.
module gpu_job_fifo
    import gpu_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  gpu_job_t                 push_dat,
    input  logic                     pop,
    output gpu_job_t                 head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    gpu_job_t    mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= push_dat;
    end

    assign head_dat = mem_q[rd_ptr_q[PW-1:0]];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/gpu_job_scheduler.sv
// Queues matrix jobs, dispatches round-robin to idle enabled units, returns completions by tag.
// Latency: accept->unit_start 1 cycle; unit_done->cmpl_valid 1 cycle. Watchdog under GPU_SCHED_TIMEOUT_EN.
// Backpressure: job_ready drops when the queue is full; cmpl_* holds until cmpl_ready.
module gpu_job_scheduler
    import gpu_sched_pkg::*;
#(
    parameter int NUM_UNITS      = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int CFG_WIDTH      = 16,
    parameter int TAG_WIDTH      = 4,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [ADDR_WIDTH-1:0]           job_a_addr,
    input  logic [ADDR_WIDTH-1:0]           job_b_addr,
    input  logic [ADDR_WIDTH-1:0]           job_c_addr,
    input  logic [CFG_WIDTH-1:0]            job_cfg,
    input  logic [TAG_WIDTH-1:0]            job_tag,
    input  logic [NUM_UNITS-1:0]            unit_enable,
    input  logic [NUM_UNITS-1:0]            unit_busy,
    input  logic [NUM_UNITS-1:0]            unit_done,
    output logic [NUM_UNITS-1:0]            unit_start,
    output logic [NUM_UNITS*ADDR_WIDTH-1:0] unit_a_addr,
    output logic [NUM_UNITS*ADDR_WIDTH-1:0] unit_b_addr,
    output logic [NUM_UNITS*ADDR_WIDTH-1:0] unit_c_addr,
    output logic [NUM_UNITS*CFG_WIDTH-1:0]  unit_cfg,
    output logic                            cmpl_valid,
    input  logic                            cmpl_ready,
    output logic [TAG_WIDTH-1:0]            cmpl_tag,
    output logic [$clog2(NUM_UNITS)-1:0]    cmpl_unit,
    output logic                            cmpl_err,
    output logic [$clog2(QUEUE_DEPTH):0]    queue_count,
    output logic [NUM_UNITS-1:0]            reserved,
    output logic                            err_spurious_done
);

    gpu_job_t in_job, head_job;
    logic     fifo_full, fifo_empty, push, dispatch, hs;
    logic [UNIT_IDX_W-1:0] sel;
    logic [NUM_UNITS-1:0]  elig, done_hit, to_hit, cand, perr_q;

    logic [NUM_UNITS-1:0]                 start_q, start_d, reserved_q, reserved_d, pending_q, pending_d;
    logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [NUM_UNITS-1:0][CFG_WIDTH-1:0]  cfg_q, cfg_d;
    logic [NUM_UNITS-1:0][TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [UNIT_IDX_W-1:0]                rr_ptr_q, rr_ptr_d, cmpl_unit_q, cmpl_unit_d;
    logic [TAG_WIDTH-1:0]                 cmpl_tag_q, cmpl_tag_d;
    logic cmpl_vld_q, cmpl_vld_d, cmpl_err_q, cmpl_err_d, spur_q, spur_d;

    assign in_job.a_addr = job_a_addr;
    assign in_job.b_addr = job_b_addr;
    assign in_job.c_addr = job_c_addr;
    assign in_job.cfg    = job_cfg;
    assign in_job.tag    = job_tag;

    assign job_ready = ~fifo_full;
    assign push      = job_valid & ~fifo_full;
    assign elig      = unit_enable & ~unit_busy & ~reserved_q;
    assign dispatch  = ~fifo_empty & (|elig);
    assign sel       = rr_pick(elig, rr_ptr_q);
    assign hs        = cmpl_vld_q & cmpl_ready;
    assign done_hit  = unit_done & reserved_q & ~pending_q;

    gpu_job_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (in_job),
        .pop      (dispatch),
        .head_dat (head_job),
        .count    (queue_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        start_d     = '0;
        reserved_d  = reserved_q;
        pending_d   = pending_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        cfg_d       = cfg_q;
        tag_d       = tag_q;
        rr_ptr_d    = rr_ptr_q;
        cmpl_vld_d  = cmpl_vld_q;
        cmpl_unit_d = cmpl_unit_q;
        cmpl_tag_d  = cmpl_tag_q;
        cmpl_err_d  = cmpl_err_q;
        spur_d      = spur_q | (|(unit_done & ~reserved_q));
        cand        = pending_q;

        // The retiring unit stays reserved until this edge, so it cannot be redispatched yet.
        if (hs) begin
            reserved_d[cmpl_unit_q] = 1'b0;
            pending_d[cmpl_unit_q]  = 1'b0;
            cand[cmpl_unit_q]       = 1'b0;
        end
        pending_d = pending_d | done_hit | to_hit;

        if (dispatch) begin
            start_d[sel]    = 1'b1;
            reserved_d[sel] = 1'b1;
            a_d[sel]        = head_job.a_addr;
            b_d[sel]        = head_job.b_addr;
            c_d[sel]        = head_job.c_addr;
            cfg_d[sel]      = head_job.cfg;
            tag_d[sel]      = head_job.tag;
            rr_ptr_d        = (sel == UNIT_IDX_W'(NUM_UNITS-1)) ? '0 : sel + 1'b1;
        end

        // Completion slot reloads with the lowest pending unit only when empty or draining.
        if (!cmpl_vld_q || hs) begin
            cmpl_vld_d = |cand;
            if (|cand) begin
                for (int i = NUM_UNITS-1; i >= 0; i--) begin
                    if (cand[i]) cmpl_unit_d = UNIT_IDX_W'(i);
                end
                cmpl_tag_d = tag_q[cmpl_unit_d];
                cmpl_err_d = perr_q[cmpl_unit_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= '0;
            reserved_q  <= '0;
            pending_q   <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            cfg_q       <= '0;
            tag_q       <= '0;
            rr_ptr_q    <= '0;
            cmpl_vld_q  <= 1'b0;
            cmpl_unit_q <= '0;
            cmpl_tag_q  <= '0;
            cmpl_err_q  <= 1'b0;
            spur_q      <= 1'b0;
        end else begin
            start_q     <= start_d;
            reserved_q  <= reserved_d;
            pending_q   <= pending_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            cfg_q       <= cfg_d;
            tag_q       <= tag_d;
            rr_ptr_q    <= rr_ptr_d;
            cmpl_vld_q  <= cmpl_vld_d;
            cmpl_unit_q <= cmpl_unit_d;
            cmpl_tag_q  <= cmpl_tag_d;
            cmpl_err_q  <= cmpl_err_d;
            spur_q      <= spur_d;
        end
    end

`ifdef GPU_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [NUM_UNITS-1:0][15:0] wd_q, wd_d;
    logic [NUM_UNITS-1:0]       perr_d;

    // A real done arriving on the expiry edge wins over the timeout.
    always_comb begin
        wd_d   = wd_q;
        perr_d = perr_q;
        to_hit = '0;
        if (hs) perr_d[cmpl_unit_q] = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (dispatch && sel == UNIT_IDX_W'(u)) begin
                wd_d[u] = '0;
            end else if (reserved_q[u] && !pending_q[u]) begin
                wd_d[u] = wd_q[u] + 16'd1;
                if (wd_q[u] == TO_LAST && !unit_done[u]) begin
                    to_hit[u] = 1'b1;
                    perr_d[u] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q   <= '0;
            perr_q <= '0;
        end else begin
            wd_q   <= wd_d;
            perr_q <= perr_d;
        end
    end
`else
    assign to_hit = '0;
    assign perr_q = '0;
`endif

    assign unit_start        = start_q;
    assign unit_a_addr       = a_q;
    assign unit_b_addr       = b_q;
    assign unit_c_addr       = c_q;
    assign unit_cfg          = cfg_q;
    assign cmpl_valid        = cmpl_vld_q;
    assign cmpl_tag          = cmpl_tag_q;
    assign cmpl_unit         = cmpl_unit_q;
    assign cmpl_err          = cmpl_err_q;
    assign reserved          = reserved_q;
    assign err_spurious_done = spur_q;

endmodule
